// File: rtl/piano_pkg.sv
// Shared types and constants for the piano track-player control blocks.
package piano_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        PLAYING = 2'd1,
        PAUSED  = 2'd2,
        GAP     = 2'd3
    } seq_state_t;

    localparam logic [1:0] MODE_SINGLE  = 2'b00;
    localparam logic [1:0] MODE_REPEAT  = 2'b01;
    localparam logic [1:0] MODE_LOOP    = 2'b10;
    localparam logic [1:0] MODE_THROUGH = 2'b11;

    localparam int TRACK_W = 4;

    // Counter width able to hold 0..cycles, never narrower than one bit.
    function automatic int gap_cnt_w(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/gap_timer.sv
// Up-counting silence timer: counts 0..CYCLES-1 while enabled and flags the last cycle.
module gap_timer
    import piano_pkg::*;
#(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int W      = gap_cnt_w(CYCLES);
    localparam int LAST_I = (CYCLES > 0) ? CYCLES - 1 : 0;
    localparam logic [W-1:0] LAST = W'(LAST_I);

    logic [W-1:0] count;

    assign done = enable && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || done) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/track_sequencer.sv
// Track player controller: owns track selection and run/pause state, sequences gaps and auto-advance.
//   state   | meaning
//   STOPPED | idle, player halted
//   PLAYING | player running the current track
//   PAUSED  | player halted, resumable without restart
//   GAP     | silent interval before the next track starts
module track_sequencer
    import piano_pkg::*;
#(
    parameter int NUM_TRACKS = 16,
    parameter int GAP_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_play,
    input  logic               btn_stop,
    input  logic               btn_next,
    input  logic               btn_prev,
    input  logic [1:0]         mode,
    input  logic               song_done,
    output logic [TRACK_W-1:0] current_track,
    output logic               playing,
    output logic               song_start,
    output logic               in_gap
);

    localparam logic [TRACK_W-1:0] LAST_TRACK = TRACK_W'(NUM_TRACKS - 1);

    seq_state_t         state, nxt_state;
    logic [TRACK_W-1:0] nxt_track, inc_track, dec_track, follow_track;
    logic               nxt_start, follow, nav;
    logic               gap_clear, gap_en, gap_done;

    assign nav       = btn_next ^ btn_prev;
    assign inc_track = (current_track == LAST_TRACK) ? '0 : current_track + 1'b1;
    assign dec_track = (current_track == '0) ? LAST_TRACK : current_track - 1'b1;

    assign gap_en    = (state == GAP);
    // Counter sits at zero outside the gap and restarts on every entry.
    assign gap_clear = (state != GAP) || (nxt_state != GAP);

    gap_timer #(.CYCLES(GAP_CYCLES)) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (gap_clear),
        .enable (gap_en),
        .done   (gap_done)
    );

    always_comb begin
        nxt_state    = state;
        nxt_track    = current_track;
        nxt_start    = 1'b0;
        follow       = 1'b0;
        follow_track = current_track;

        if (btn_stop) begin
            nxt_state = STOPPED;
        end else if (nav) begin
            nxt_track = btn_next ? inc_track : dec_track;
            if (state == PLAYING || state == GAP) begin
                nxt_state = PLAYING;
                nxt_start = 1'b1;
            end else begin
                nxt_state = STOPPED;
            end
        end else if (btn_play) begin
            case (state)
                STOPPED: begin
                    nxt_state = PLAYING;
                    nxt_start = 1'b1;
                end
                PLAYING: nxt_state = PAUSED;
                PAUSED:  nxt_state = PLAYING;
                default: nxt_state = STOPPED;
            endcase
        end else if (song_done && state == PLAYING) begin
            case (mode)
                MODE_SINGLE: nxt_state = STOPPED;
                MODE_REPEAT: follow = 1'b1;
                MODE_LOOP: begin
                    follow       = 1'b1;
                    follow_track = inc_track;
                end
                default: begin
                    if (current_track == LAST_TRACK) begin
                        nxt_state = STOPPED;
                    end else begin
                        follow       = 1'b1;
                        follow_track = inc_track;
                    end
                end
            endcase
        end else if (gap_done) begin
            nxt_state = PLAYING;
            nxt_start = 1'b1;
        end

        if (follow) begin
            nxt_track = follow_track;
            if (GAP_CYCLES == 0) begin
                nxt_state = PLAYING;
                nxt_start = 1'b1;
            end else begin
                nxt_state = GAP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= STOPPED;
            current_track <= '0;
            playing       <= 1'b0;
            song_start    <= 1'b0;
            in_gap        <= 1'b0;
        end else begin
            state         <= nxt_state;
            current_track <= nxt_track;
            playing       <= (nxt_state == PLAYING);
            song_start    <= nxt_start;
            in_gap        <= (nxt_state == GAP);
        end
    end

endmodule

// File: tb/tb_track_sequencer.sv
// Self-checking bench for track_sequencer: directed vector table, hand corner cases, random vs model.
module tb_track_sequencer;

    localparam int N = 16;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_play, btn_stop, btn_next, btn_prev, song_done;
    logic [1:0] mode;
    logic [3:0] current_track, current_track0;
    logic       playing, song_start, in_gap;
    logic       playing0, song_start0, in_gap0;

    always #5 clk = ~clk;

    track_sequencer #(.NUM_TRACKS(N), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .btn_play(btn_play), .btn_stop(btn_stop),
        .btn_next(btn_next), .btn_prev(btn_prev), .mode(mode), .song_done(song_done),
        .current_track(current_track), .playing(playing), .song_start(song_start), .in_gap(in_gap)
    );

    track_sequencer #(.NUM_TRACKS(N), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .btn_play(btn_play), .btn_stop(btn_stop),
        .btn_next(btn_next), .btn_prev(btn_prev), .mode(mode), .song_done(song_done),
        .current_track(current_track0), .playing(playing0), .song_start(song_start0), .in_gap(in_gap0)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit       play, stop, next, prev, done;
        bit [1:0] mode;
        int       trk;
        bit       pl, ss, gp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit p, bit s, bit n, bit pr, bit d, bit [1:0] m,
                                int trk, bit pl, bit ss, bit gp);
        vec_t v;
        v.play = p; v.stop = s; v.next = n; v.prev = pr; v.done = d; v.mode = m;
        v.trk = trk; v.pl = pl; v.ss = ss; v.gp = gp;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input int trk, input bit pl,
                           input bit ss, input bit gp);
        chk({tag, ".track"},      idx, current_track, trk);
        chk({tag, ".playing"},    idx, playing, pl);
        chk({tag, ".song_start"}, idx, song_start, ss);
        chk({tag, ".in_gap"},     idx, in_gap, gp);
    endtask

    // Inputs change 1 unit after an edge, are sampled at the next edge, outputs read 1 unit later.
    task automatic drive(input bit p, input bit s, input bit n, input bit pr, input bit d,
                         input bit [1:0] m);
        btn_play = p; btn_stop = s; btn_next = n; btn_prev = pr; song_done = d; mode = m;
        @(posedge clk);
        #1;
        btn_play = 0; btn_stop = 0; btn_next = 0; btn_prev = 0; song_done = 0;
    endtask

    // Reference model: 0 stopped, 1 playing, 2 paused, 3 gap; gap_left counts silent cycles remaining.
    int m_st, m_trk, m_left;
    bit m_start;

    task automatic m_follow(input int t);
        m_trk = t;
        if (G == 0) begin
            m_st = 1; m_start = 1;
        end else begin
            m_st = 3; m_left = G;
        end
    endtask

    task automatic model_step(input bit p, input bit s, input bit n, input bit pr, input bit d,
                              input bit [1:0] m);
        m_start = 0;
        if (s) begin
            m_st = 0;
        end else if (n != pr) begin
            m_trk = n ? (m_trk + 1) % N : (m_trk + N - 1) % N;
            if (m_st == 1 || m_st == 3) begin
                m_st = 1; m_start = 1;
            end else begin
                m_st = 0;
            end
        end else if (p) begin
            if (m_st == 0)      begin m_st = 1; m_start = 1; end
            else if (m_st == 1) m_st = 2;
            else if (m_st == 2) m_st = 1;
            else                m_st = 0;
        end else if (d && m_st == 1) begin
            if (m == 0)                       m_st = 0;
            else if (m == 1)                  m_follow(m_trk);
            else if (m == 2)                  m_follow((m_trk + 1) % N);
            else if (m_trk == N - 1)          m_st = 0;
            else                              m_follow(m_trk + 1);
        end else if (m_st == 3) begin
            m_left--;
            if (m_left == 0) begin
                m_st = 1; m_start = 1;
            end
        end
    endtask

    initial begin
        rst = 1; btn_play = 0; btn_stop = 0; btn_next = 0; btn_prev = 0; song_done = 0; mode = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        rst = 0;

        add(1,0,0,0,0,0,  0,1,1,0);
        add(0,0,0,0,0,0,  0,1,0,0);
        add(1,0,0,0,0,0,  0,0,0,0);
        add(1,0,0,0,0,0,  0,1,0,0);
        add(0,0,0,0,1,0,  0,0,0,0);
        add(0,0,0,1,0,0, 15,0,0,0);
        add(1,0,0,0,0,2, 15,1,1,0);
        add(0,0,0,0,0,2, 15,1,0,0);
        add(0,0,0,0,1,2,  0,0,0,1);
        for (int i = 0; i < 3; i++) add(0,0,0,0,0,2, 0,0,0,1);
        add(0,0,0,0,0,2,  0,1,1,0);
        add(0,0,0,0,0,2,  0,1,0,0);
        add(0,0,1,0,0,2,  1,1,1,0);
        add(0,0,0,0,0,2,  1,1,0,0);
        add(0,1,1,0,0,2,  1,0,0,0);
        add(1,0,1,1,0,2,  1,1,1,0);
        add(1,0,0,0,0,2,  1,0,0,0);
        add(0,0,0,0,1,2,  1,0,0,0);
        add(1,0,0,0,0,2,  1,1,0,0);
        add(0,0,0,1,0,2,  0,1,1,0);
        add(0,0,0,0,0,2,  0,1,0,0);
        add(0,0,0,1,0,2, 15,1,1,0);
        add(0,0,0,0,0,3, 15,1,0,0);
        add(0,0,0,0,1,3, 15,0,0,0);
        add(0,0,1,0,0,3,  0,0,0,0);
        for (int i = 1; i <= 5; i++) add(0,0,1,0,0,1, i,0,0,0);
        add(1,0,0,0,0,1,  5,1,1,0);
        add(0,0,0,0,0,1,  5,1,0,0);
        add(0,0,0,0,1,1,  5,0,0,1);
        for (int i = 0; i < 3; i++) add(0,0,0,0,0,1, 5,0,0,1);
        add(0,0,0,0,0,1,  5,1,1,0);
        add(0,0,0,0,0,2,  5,1,0,0);
        add(0,0,0,0,1,2,  6,0,0,1);
        add(1,0,0,0,0,2,  6,0,0,0);
        add(1,0,0,0,0,2,  6,1,1,0);
        add(0,0,0,0,0,2,  6,1,0,0);
        add(0,0,0,0,1,2,  7,0,0,1);
        add(0,0,0,0,0,2,  7,0,0,1);
        add(0,0,1,0,0,2,  8,1,1,0);
        add(0,0,0,0,0,3,  8,1,0,0);
        add(0,0,0,0,1,3,  9,0,0,1);
        add(0,1,0,0,0,3,  9,0,0,0);
        add(0,0,0,0,1,2,  9,0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].play, vecs[i].stop, vecs[i].next, vecs[i].prev, vecs[i].done, vecs[i].mode);
            chk_all("vec", i, vecs[i].trk, vecs[i].pl, vecs[i].ss, vecs[i].gp);
        end

        // Zero-gap instance and reset landing in the middle of a gap.
        rst = 1; #1; rst = 0;
        drive(1,0,0,0,0,2);
        chk_all("midgap", 0, 0, 1, 1, 0);
        drive(0,0,0,0,1,2);
        chk_all("midgap", 1, 1, 0, 0, 1);
        chk("nogap.track", 1, current_track0, 1);
        chk("nogap.playing", 1, playing0, 1);
        chk("nogap.song_start", 1, song_start0, 1);
        chk("nogap.in_gap", 1, in_gap0, 0);
        drive(0,0,0,0,0,2);
        chk("nogap.song_start", 2, song_start0, 0);
        drive(0,0,0,0,0,2);
        chk_all("midgap", 3, 1, 0, 0, 1);
        #2 rst = 1;
        #1;
        chk_all("midgap_rst", 4, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 0;
        drive(1,0,0,0,0,2);
        chk_all("midgap", 5, 0, 1, 1, 0);

        // Randomized run against the reference model.
        rst = 1; #1; rst = 0;
        m_st = 0; m_trk = 0; m_left = 0; m_start = 0;
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            bit p, s, n, pr, d;
            bit [1:0] m;
            p  = ($urandom_range(0, 99) < 8);
            s  = ($urandom_range(0, 99) < 3);
            n  = ($urandom_range(0, 99) < 6);
            pr = ($urandom_range(0, 99) < 6);
            d  = ($urandom_range(0, 99) < 20);
            m  = ($urandom_range(0, 99) < 5) ? 2'($urandom_range(0, 3)) : mode;
            drive(p, s, n, pr, d, m);
            model_step(p, s, n, pr, d, m);
            chk_all("rand", i, m_trk, m_st == 1, m_start, m_st == 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
